// File: rtl/axi_7seg_regs.sv
// axi_7seg_regs
// -------------
// AXI4-Lite slave for the Pmod two-digit 7-segment display. Four 32-bit
// read/write registers (CTRL, DATA, PRESCALE, SCRATCH) are decoded from
// address bits [3:2]. The display engine multiplexes the two digits using a
// 16-bit down-counter reloaded from PRESCALE.
//
// Ports:
//   s00_axi_aclk, s00_axi_areset   clock, synchronous active-high reset
//   s00_axi_aw*/w*/b*              AXI4-Lite write address/data/response
//   s00_axi_ar*/r*                 AXI4-Lite read address/data
//   seg[6:0]                       active-high segments, seg[0]=a .. seg[6]=g
//   sel                            digit select, 0 = right, 1 = left
//
// Optional feature macro: AXI_7SEG_RAW_EN
//   When defined, CTRL[1]=1 drives seg straight from DATA[6:0] / DATA[14:8].
//   When undefined, CTRL[1] is storage only and hex decode is always used.

module axi_7seg_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [6:0]                      seg,
  output logic                            sel
);

  localparam int REG_CTRL     = 0;
  localparam int REG_DATA     = 1;
  localparam int REG_PRESCALE = 2;

  // Register file: index 0 CTRL, 1 DATA, 2 PRESCALE, 3 SCRATCH
  logic [3:0][31:0] regs_q, regs_d;

  logic        awready_q, awready_d;
  logic        wready_q,  wready_d;
  logic        bvalid_q,  bvalid_d;
  logic        arready_q, arready_d;
  logic        rvalid_q,  rvalid_d;
  logic [31:0] rdata_q,   rdata_d;

  logic [15:0] cnt_q, cnt_d;
  logic        sel_q, sel_d;
  logic [6:0]  seg_q, seg_d;

  logic        aw_accept;
  logic        wr_hs;
  logic        ar_accept;
  logic        rd_hs;
  logic        disp_en;
  logic        raw_mode;
  logic [15:0] reload;
  logic [3:0]  nibble;
  logic [1:0]  wr_idx;
  logic [1:0]  rd_idx;

  // Only word addressing is decoded; the byte-offset bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Write channel. AW and W are only taken together; ready pulses for one
  // cycle and the handshake edge (ready & valid) performs the register write
  // and raises bvalid. No new write is taken while a response is pending.
  always_comb begin
    wr_idx    = s00_axi_awaddr[3:2];
    aw_accept = s00_axi_awvalid && s00_axi_wvalid && !awready_q && !bvalid_q;
    wr_hs     = awready_q && wready_q && s00_axi_awvalid && s00_axi_wvalid;
    awready_d = aw_accept;
    wready_d  = aw_accept;
    regs_d    = regs_q;
    bvalid_d  = bvalid_q;
    if (wr_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (s00_axi_wstrb[b]) begin
          regs_d[wr_idx][b*8 +: 8] = s00_axi_wdata[b*8 +: 8];
        end
      end
      bvalid_d = 1'b1;
    end else if (bvalid_q && s00_axi_bready) begin
      bvalid_d = 1'b0;
    end
  end

  // Read channel. rdata is sampled from the current (pre-write) register
  // contents, so a same-cycle write to the same register is not visible.
  always_comb begin
    rd_idx    = s00_axi_araddr[3:2];
    ar_accept = s00_axi_arvalid && !arready_q && !rvalid_q;
    rd_hs     = arready_q && s00_axi_arvalid;
    arready_d = ar_accept;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;
    if (rd_hs) begin
      rdata_d  = regs_q[rd_idx];
      rvalid_d = 1'b1;
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Display engine. seg is decoded from sel_d so that seg and sel always
  // update on the same edge. A new PRESCALE only lands at the next reload.
  always_comb begin
    disp_en = regs_q[REG_CTRL][0];
`ifdef AXI_7SEG_RAW_EN
    raw_mode = regs_q[REG_CTRL][1];
`else
    raw_mode = 1'b0;
`endif
    reload = regs_q[REG_PRESCALE][15:0];
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    if (!disp_en) begin
      cnt_d = reload;
      sel_d = 1'b0;
    end else if (cnt_q == 16'd0) begin
      cnt_d = reload;
      sel_d = ~sel_q;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end

    nibble = sel_d ? regs_q[REG_DATA][7:4] : regs_q[REG_DATA][3:0];
    if (!disp_en) begin
      seg_d = 7'h00;
    end else if (raw_mode) begin
      seg_d = sel_d ? regs_q[REG_DATA][14:8] : regs_q[REG_DATA][6:0];
    end else begin
      seg_d = hex_to_seg(nibble);
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      regs_q    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      cnt_q     <= 16'h0;
      sel_q     <= 1'b0;
      seg_q     <= 7'h00;
    end else begin
      regs_q    <= regs_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign seg             = seg_q;
  assign sel             = sel_q;

endmodule

// File: tb/tb_axi_7seg_regs.sv
// tb_axi_7seg_regs
// ----------------
// Directed bench for axi_7seg_regs: register write/read-back, byte strobes,
// hex decode and digit multiplexing, raw mode (AXI_7SEG_RAW_EN aware),
// response backpressure on both channels and reset in the middle of a write.

module tb_axi_7seg_regs;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [6:0]  seg;
  logic        sel;

  int vec_count  = 0;
  int miscompares = 0;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  axi_7seg_regs dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (areset),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .seg             (seg),
    .sel             (sel)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a write on the AW and W channels together
  task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = 1'b1;
  endtask

  // Full write; with hold_b set the response is left pending (bready=0)
  task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit hold_b);
    bit seen;
    bready = !hold_b;
    applyStimulus(addr, data, strb);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (awready && wready) seen = 1'b1;
    end
    checkOutput("wr_ready_seen", 32'(seen), 32'd1);
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    checkOutput("bvalid_rise", 32'(bvalid), 32'd1);
    checkOutput("bresp_okay", 32'(bresp), 32'd0);
    if (!hold_b) begin
      tick();
      checkOutput("bvalid_fall", 32'(bvalid), 32'd0);
    end
  endtask

  // Full read; rready is held low for hold_cycles while rvalid/rdata must stay put
  task automatic axiRead(input string tag, input logic [3:0] addr,
                         input logic [31:0] expected, input int hold_cycles);
    bit seen;
    rready  = 1'b0;
    araddr  = addr;
    arvalid = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (arready) seen = 1'b1;
    end
    checkOutput("rd_ready_seen", 32'(seen), 32'd1);
    tick();
    arvalid = 1'b0;
    checkOutput("rvalid_rise", 32'(rvalid), 32'd1);
    checkOutput(tag, rdata, expected);
    checkOutput("rresp_okay", 32'(rresp), 32'd0);
    for (int n = 0; n < hold_cycles; n++) begin
      tick();
      checkOutput("rvalid_hold", 32'(rvalid), 32'd1);
      checkOutput("rdata_hold", rdata, expected);
    end
    rready = 1'b1;
    tick();
    checkOutput("rvalid_fall", 32'(rvalid), 32'd0);
    rready = 1'b0;
  endtask

  // Count cycles until sel reaches val (bounded)
  task automatic waitSel(input logic val, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (sel !== val && cycles < 60);
  endtask

  // With PRESCALE=3 each digit must be shown for exactly 4 cycles
  task automatic checkMux(input string tag, input logic [6:0] exp_right,
                          input logic [6:0] exp_left);
    int cycles;
    waitSel(1'b0, cycles);
    waitSel(1'b1, cycles);
    checkOutput({tag, "_sel1_reached"}, 32'(sel), 32'd1);
    checkOutput({tag, "_seg_left"}, 32'(seg), 32'(exp_left));
    waitSel(1'b0, cycles);
    checkOutput({tag, "_left_period"}, cycles, 32'd4);
    checkOutput({tag, "_seg_right"}, 32'(seg), 32'(exp_right));
    waitSel(1'b1, cycles);
    checkOutput({tag, "_right_period"}, cycles, 32'd4);
    checkOutput({tag, "_seg_left2"}, 32'(seg), 32'(exp_left));
  endtask

  initial begin
    logic [6:0] raw_right;
    logic [6:0] raw_left;

    areset  = 1'b1;
    awaddr  = 4'h0;
    awvalid = 1'b0;
    wdata   = 32'h0;
    wstrb   = 4'h0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    araddr  = 4'h0;
    arvalid = 1'b0;
    rready  = 1'b0;
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_awready", 32'(awready), 32'd0);
    checkOutput("rst_wready", 32'(wready), 32'd0);
    checkOutput("rst_bvalid", 32'(bvalid), 32'd0);
    checkOutput("rst_arready", 32'(arready), 32'd0);
    checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_seg", 32'(seg), 32'd0);
    checkOutput("rst_sel", 32'(sel), 32'd0);
    areset = 1'b0;
    tick();

    $display("[TB] write/read-back");
    axiWrite(4'h0, 32'h1, 4'hF, 1'b0);
    axiWrite(4'h4, 32'h2, 4'hF, 1'b0);
    axiWrite(4'h8, 32'h3, 4'hF, 1'b0);
    axiWrite(4'hC, 32'h4, 4'hF, 1'b0);
    axiRead("rd_ctrl", 4'h0, 32'h1, 0);
    axiRead("rd_data", 4'h4, 32'h2, 0);
    axiRead("rd_prescale", 4'h8, 32'h3, 0);
    axiRead("rd_scratch", 4'hC, 32'h4, 0);

    $display("[TB] byte strobes");
    axiWrite(4'hC, 32'hFFFF_FFFF, 4'hF, 1'b0);
    axiWrite(4'hC, 32'h0000_0000, 4'b0101, 1'b0);
    axiRead("rd_strobe", 4'hC, 32'hFF00_FF00, 0);

    $display("[TB] decode and multiplex");
    axiWrite(4'h8, 32'h3, 4'hF, 1'b0);
    axiWrite(4'h4, 32'hA5, 4'hF, 1'b0);
    axiWrite(4'h0, 32'h1, 4'hF, 1'b0);
    checkMux("hex", SEG_TAB[5], SEG_TAB[10]);

    $display("[TB] raw mode");
`ifdef AXI_7SEG_RAW_EN
    raw_right = 7'h01;
    raw_left  = 7'h7F;
`else
    raw_right = SEG_TAB[1];
    raw_left  = SEG_TAB[0];
`endif
    axiWrite(4'h4, 32'h7F01, 4'hF, 1'b0);
    axiWrite(4'h0, 32'h3, 4'hF, 1'b0);
    checkMux("raw", raw_right, raw_left);
    axiRead("rd_ctrl_raw", 4'h0, 32'h3, 0);

    $display("[TB] write backpressure");
    axiWrite(4'hC, 32'h1234_5678, 4'hF, 1'b1);
    for (int n = 0; n < 10; n++) begin
      applyStimulus(4'hC, 32'hCAFE_F00D, 4'hF);
      tick();
      checkOutput("bp_bvalid_hold", 32'(bvalid), 32'd1);
      checkOutput("bp_awready_low", 32'(awready), 32'd0);
    end
    axiRead("rd_bp_first", 4'hC, 32'h1234_5678, 0);
    axiWrite(4'hC, 32'hCAFE_F00D, 4'hF, 1'b0);

    $display("[TB] read backpressure");
    axiRead("rd_bp_second", 4'hC, 32'hCAFE_F00D, 10);

    $display("[TB] reset mid-operation");
    axiWrite(4'h0, 32'h1, 4'hF, 1'b0);
    axiWrite(4'h4, 32'h55, 4'hF, 1'b1);
    checkOutput("pre_rst_bvalid", 32'(bvalid), 32'd1);
    areset = 1'b1;
    tick();
    checkOutput("mid_rst_awready", 32'(awready), 32'd0);
    checkOutput("mid_rst_wready", 32'(wready), 32'd0);
    checkOutput("mid_rst_bvalid", 32'(bvalid), 32'd0);
    checkOutput("mid_rst_arready", 32'(arready), 32'd0);
    checkOutput("mid_rst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("mid_rst_rdata", rdata, 32'd0);
    checkOutput("mid_rst_seg", 32'(seg), 32'd0);
    checkOutput("mid_rst_sel", 32'(sel), 32'd0);
    areset = 1'b0;
    bready = 1'b1;
    tick();
    checkOutput("post_rst_seg", 32'(seg), 32'd0);
    axiRead("rst_rd_ctrl", 4'h0, 32'h0, 0);
    axiRead("rst_rd_data", 4'h4, 32'h0, 0);
    axiRead("rst_rd_prescale", 4'h8, 32'h0, 0);
    axiRead("rst_rd_scratch", 4'hC, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_7seg_regs.md
# axi_7seg_regs

AXI4-Lite slave for the Pmod 7-segment peripheral. It owns four 32-bit read/write registers and drives the two-digit multiplexed display from them. It sits behind the AXI interconnect as the S00_AXI responder and is the end that the block-design master VIP writes and reads back.

## Interface

**Parameters**
- `C_S_AXI_DATA_WIDTH`, default 32: data width. Only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, default 4: byte address width. Only bits [3:2] are decoded.

**Ports** (clock and reset first)
- `s00_axi_aclk`  in  1  sole clock; every output is registered on its rising edge.
- `s00_axi_areset`  in  1  reset, synchronous, active-high.
- `s00_axi_awaddr`  in  4  write address.
- `s00_axi_awvalid` / `s00_axi_awready`  in/out  1  write-address handshake.
- `s00_axi_wdata`  in  32  write data.
- `s00_axi_wstrb`  in  4  byte strobes.
- `s00_axi_wvalid` / `s00_axi_wready`  in/out  1  write-data handshake.
- `s00_axi_bresp`  out  2  write response, always 2'b00 (OKAY).
- `s00_axi_bvalid` / `s00_axi_bready`  out/in  1  write-response handshake.
- `s00_axi_araddr`  in  4  read address.
- `s00_axi_arvalid` / `s00_axi_arready`  in/out  1  read-address handshake.
- `s00_axi_rdata`  out  32  read data.
- `s00_axi_rresp`  out  2  read response, always 2'b00.
- `s00_axi_rvalid` / `s00_axi_rready`  out/in  1  read-data handshake.
- `seg`  out  7  segments, active-high; seg[0]=a … seg[6]=g.
- `sel`  out  1  digit select: 0 = right digit, 1 = left digit.

## Operation

**Register map** (byte offsets; all fields R/W, full 32 bits, reset value 0)
- 0x0 CTRL: bit0 enables the display; bit1 selects raw mode (see Configuration).
- 0x4 DATA: [3:0] right nibble, [7:4] left nibble; raw mode uses [6:0] right and [14:8] left.
- 0x8 PRESCALE: [15:0] reload value R.
- 0xC SCRATCH: no hardware effect.

**Write channel**
- Idle: awready=0, wready=0.
- When awvalid and wvalid are both high and bvalid=0, raise awready and wready together for exactly one cycle. The register update happens on that edge.
- Each byte lane n is written only when wstrb[n]=1.
- bvalid rises on the next cycle and holds until bready is sampled high.
- A new write is not accepted while bvalid=1.
- AW without W, or W without AW, is not accepted; it waits.

**Read channel**
- When arvalid=1 and rvalid=0, pulse arready for one cycle and capture the register selected by araddr[3:2] into rdata.
- rvalid rises on the next cycle. rdata and rvalid hold until rready.

**Read/write collision**
- If a read to the same register is accepted in the same cycle as a write, rdata returns the pre-write value.

**Display engine**
- 16-bit down-counter `cnt`.
- When CTRL[0]=1: on cnt==0, toggle sel and reload cnt=R; otherwise decrement. sel therefore toggles every R+1 cycles, and R=0 toggles every cycle.
- When CTRL[0]=0: seg=0, sel=0, cnt=R.
- Hex decode, digit 0–F → 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- seg shows the nibble for the currently selected digit and is registered in the same cycle sel changes, so seg and sel never disagree.

## Timing

- **Reset** (one edge with s00_axi_areset=1): awready, wready, bvalid, arready, rvalid, rdata, seg, sel and cnt all go to 0, and all registers clear. A transaction in flight is dropped with no response; the master must reissue it.
- **Write:** AW/W acceptance occurs on the first edge where both valids are high. bvalid follows one cycle later. Minimum write-to-write spacing is 3 cycles with bready tied high.
- **Read:** arready occurs on the first edge arvalid is seen with rvalid=0. rvalid follows one cycle later, so data is returned 2 cycles after arvalid.
- **Independence:** reads and writes proceed concurrently.
- **Register effect:** a CTRL, DATA or PRESCALE write affects seg/sel from the cycle after the write handshake. A PRESCALE change takes effect at the next reload and does not truncate the current count.

## Configuration

- `AXI_7SEG_RAW_EN` defined: when CTRL[1]=1, seg is driven directly from DATA[6:0] (right digit) or DATA[14:8] (left digit), bypassing the hex decoder.
- `AXI_7SEG_RAW_EN` undefined: CTRL[1] is stored and read back but ignored; hex decode is always used.

## Test plan

- **Write/read-back:** write 0x1, 0x2, 0x3, 0x4 to offsets 0x0, 0x4, 0x8, 0xC, then read all four → 0x1, 0x2, 0x3, 0x4, every bresp/rresp = OKAY.
- **Byte strobes:** write 0xFFFFFFFF to 0xC, then write 0x00000000 to 0xC with wstrb=4'b0101 → read returns 0xFF00FF00.
- **Decode and multiplex:** CTRL=0x1, PRESCALE=3, DATA=0xA5 → sel toggles every 4 cycles; seg=0x6D when sel=0, seg=0x77 when sel=1.
- **Raw mode:** with the macro defined, CTRL=0x3, DATA=0x7F01 → seg=0x01 when sel=0, seg=0x7F when sel=1. With the macro undefined, the same stimulus gives seg=0x06 (right digit, nibble 1) and seg=0x3F (left digit, nibble 0).
- **Backpressure:** hold bready=0 for 10 cycles after a write → bvalid stays 1 and a second AW/W is not accepted until bready goes high. Same check on the read side with rready=0: rvalid and rdata hold.
- **Reset mid-operation:** assert s00_axi_areset while bvalid=1 and the display is active → next cycle all outputs are 0 and every register reads back 0.
